// File: rtl/siw_memory_bram_initiator_pkg.sv
// Shared definitions for the BRAM initiator: FSM state encodings, write-delay
// (conf) encodings, default read latency, reservation depth and a saturating
// increment helper used by the optional event counters.
package siw_memory_bram_initiator_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] CONF_DLY0 = 2'd0;
    localparam logic [1:0] CONF_DLY1 = 2'd1;
    localparam logic [1:0] CONF_DLY2 = 2'd2;
    localparam logic [1:0] CONF_DLY3 = 2'd3;

    localparam int RD_LAT_DEF = 2;
    localparam int SLOT_DEPTH = 4;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/siw_memory_bram_initiator_if.sv
// Request/response channel of the BRAM initiator.
//   req_valid/req_ready  : request handshake (accepted when both high)
//   req_write            : 1 = write, 0 = read
//   req_addr/req_wdata   : request address and write data
//   rsp_valid/rsp_rdata  : one-cycle read response strobe and held read data
// slave  = initiator side, master = requester side.
interface siw_memory_bram_initiator_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (output req_valid, req_write, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata);
    modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/siw_memory_bram_initiator_slot_tracker.sv
// Address-bus reservation tracker for the BRAM initiator.
// r_slot[k] = bus already claimed k cycles from now by an earlier delayed write;
// the matching address/data wait in r_paddr/r_pdata until they reach slot 0.
// Ports: i_clear flushes reservations; i_acc/i_write/i_conf describe the request
// accepted this cycle; o_slot exposes the reservations; o_mem_* drive the BRAM.
// Idle cycles keep the last address/data on the bus with enable low.
module siw_memory_bram_initiator_slot_tracker
    import siw_memory_bram_initiator_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_acc,
    input  logic                  i_write,
    input  logic [1:0]            i_conf,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [SLOT_DEPTH-1:0] o_slot,
    output logic                  o_mem_enable,
    output logic [ADDR_W-1:0]     o_mem_address,
    output logic [DATA_W-1:0]     o_mem_data
);
    logic [SLOT_DEPTH-1:0] r_slot;
    logic [ADDR_W-1:0]     r_paddr [SLOT_DEPTH];
    logic [DATA_W-1:0]     r_pdata [SLOT_DEPTH];
    logic [ADDR_W-1:0]     r_last_addr;
    logic [DATA_W-1:0]     r_last_data;
    logic [SLOT_DEPTH-1:1] w_resv;
    logic                  w_direct;
    logic                  w_from_slot;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_data;

    // Reads and zero-delay writes use the bus in their own accept cycle.
    assign w_direct    = i_acc & (~i_write | (i_conf == CONF_DLY0));
    assign w_from_slot = r_slot[0] & ~i_clear;

    always_comb begin
        w_resv = '0;
        for (int k = 1; k < SLOT_DEPTH; k++)
            w_resv[k] = i_acc & i_write & (int'(i_conf) == k);
    end

    always_comb begin
        w_addr = r_last_addr;
        w_data = r_last_data;
        if (w_direct) begin
            w_addr = i_addr;
            if (i_write)
                w_data = i_wdata;
        end else if (w_from_slot) begin
            w_addr = r_paddr[0];
            w_data = r_pdata[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot      <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
            for (int k = 0; k < SLOT_DEPTH; k++) begin
                r_paddr[k] <= '0;
                r_pdata[k] <= '0;
            end
        end else begin
            r_last_addr <= w_addr;
            r_last_data <= w_data;
            for (int k = 0; k < SLOT_DEPTH - 1; k++) begin
                r_slot[k] <= ~i_clear & (r_slot[k+1] | w_resv[k+1]);
                if (w_resv[k+1]) begin
                    r_paddr[k] <= i_addr;
                    r_pdata[k] <= i_wdata;
                end else begin
                    r_paddr[k] <= r_paddr[k+1];
                    r_pdata[k] <= r_pdata[k+1];
                end
            end
            r_slot[SLOT_DEPTH-1]  <= 1'b0;
            r_paddr[SLOT_DEPTH-1] <= '0;
            r_pdata[SLOT_DEPTH-1] <= '0;
        end
    end

    assign o_slot        = r_slot;
    assign o_mem_enable  = w_direct | w_from_slot;
    assign o_mem_address = w_addr;
    assign o_mem_data    = w_data;
endmodule

// File: rtl/siw_memory_bram_initiator.sv
// Initiator for one port of a siw_memory_bram_N instance. Accepts read/write
// requests on bus (slave modport), schedules the BRAM address bus so writes
// delayed by the active conf never collide with reads, and returns read data
// RD_LAT+1 cycles after acceptance on bus.rsp_valid.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_init sync flush;
// i_conf requested write delay; o_busy; o_mem_* / i_mem_rdata BRAM port;
// o_stat_rd/_wr/_stall event counters.
// Optional feature macro: SIW_MEMORY_INITIATOR_STATS_EN builds the 16-bit
// saturating counters; otherwise the stat outputs are tied to zero.
//
//   state    | meaning
//   ST_INIT  | flushing, no requests accepted, pipes cleared
//   ST_RUN   | accepting requests with the active conf
//   ST_DRAIN | conf change pending, wait for bus/read pipe empty, then load it
module siw_memory_bram_initiator
    import siw_memory_bram_initiator_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_init,
    input  logic [1:0]                    i_conf,
    siw_memory_bram_initiator_if.slave    bus,
    output logic                          o_busy,
    output logic                          o_mem_init,
    output logic                          o_mem_enable,
    output logic                          o_mem_write_en,
    output logic [ADDR_W-1:0]             o_mem_address,
    output logic [DATA_W-1:0]             o_mem_data,
    output logic [1:0]                    o_mem_conf,
    input  logic [DATA_W-1:0]             i_mem_rdata,
    output logic [15:0]                   o_stat_rd,
    output logic [15:0]                   o_stat_wr,
    output logic [15:0]                   o_stat_stall
);
    state_e                r_state, w_state_nxt;
    logic [1:0]            r_conf;
    logic                  w_load_conf;
    logic [RD_LAT-1:0]     r_rd_pipe;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic [SLOT_DEPTH-1:0] w_slot;
    logic                  w_clear;
    logic                  w_slot_busy;
    logic                  w_acc;
    logic                  w_pending;

    assign w_clear     = i_init | (r_state == ST_INIT);
    assign w_slot_busy = bus.req_write ? w_slot[r_conf] : w_slot[0];
    // A pending conf change or flush blocks acceptance in the same cycle.
    assign bus.req_ready = (r_state == ST_RUN) & ~i_init & (i_conf == r_conf) & ~w_slot_busy;
    assign w_acc     = bus.req_valid & bus.req_ready;
    assign w_pending = (|w_slot) | (|r_rd_pipe);

    siw_memory_bram_initiator_slot_tracker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_tracker (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clear       (w_clear),
        .i_acc         (w_acc),
        .i_write       (bus.req_write),
        .i_conf        (r_conf),
        .i_addr        (bus.req_addr),
        .i_wdata       (bus.req_wdata),
        .o_slot        (w_slot),
        .o_mem_enable  (o_mem_enable),
        .o_mem_address (o_mem_address),
        .o_mem_data    (o_mem_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load_conf = 1'b0;
        case (r_state)
            ST_INIT:  w_state_nxt = ST_RUN;
            ST_RUN:   if (i_conf != r_conf) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!w_pending) begin
                          w_state_nxt = ST_RUN;
                          w_load_conf = 1'b1;
                      end
            default:  w_state_nxt = ST_INIT;
        endcase
        if (i_init) begin
            w_state_nxt = ST_INIT;
            w_load_conf = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_INIT;
            r_conf      <= CONF_DLY0;
            r_rd_pipe   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_conf)
                r_conf <= i_conf;
            if (w_clear)
                r_rd_pipe <= '0;
            else
                r_rd_pipe <= (r_rd_pipe << 1) | RD_LAT'(w_acc & ~bus.req_write);
            r_rsp_valid <= ~w_clear & r_rd_pipe[RD_LAT-1];
            if (~w_clear & r_rd_pipe[RD_LAT-1])
                r_rsp_rdata <= i_mem_rdata;
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign o_busy         = (r_state != ST_RUN) | w_pending;
    assign o_mem_init     = i_init;
    assign o_mem_write_en = w_acc & bus.req_write;
    assign o_mem_conf     = r_conf;

`ifdef SIW_MEMORY_INITIATOR_STATS_EN
    logic [15:0] r_stat_rd, r_stat_wr, r_stat_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_stall <= '0;
        end else if (i_init) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_acc & ~bus.req_write)
                r_stat_rd <= sat_inc(r_stat_rd);
            if (w_acc & bus.req_write)
                r_stat_wr <= sat_inc(r_stat_wr);
            if (bus.req_valid & ~bus.req_ready)
                r_stat_stall <= sat_inc(r_stat_stall);
        end
    end

    assign o_stat_rd    = r_stat_rd;
    assign o_stat_wr    = r_stat_wr;
    assign o_stat_stall = r_stat_stall;
`else
    assign o_stat_rd    = 16'd0;
    assign o_stat_wr    = 16'd0;
    assign o_stat_stall = 16'd0;
`endif
endmodule
